// File: rtl/alu_result_writeback.sv
// -----------------------------------------------------------------------------
// alu_result_writeback
//
// Purpose:
//   This block takes ALU results and writes them to the register file and to
//   HI/LO over a narrow bus. Accepted results wait in a small FIFO. A
//   serializer then sends them out one beat at a time:
//     - Ordinary ops (ctl_in 1-2, 5-12) send one beat of C[DATA_W-1:0] to Z/Rdest.
//     - mul (3) and div (4) send C[DATA_W-1:0] to LO, then the upper half to HI.
//     - ctl_in 0 and 13-15 complete the handshake but produce no beat.
//
// Ports:
//   clock      rising-edge clock
//   clear      synchronous active-low reset
//   res_valid  C / ctl_in valid this cycle
//   res_ready  block can accept a result (queue not full, not in reset)
//   ctl_in     opcode that produced C
//   C          2*DATA_W ALU result
//   bus_valid  bus_data / bus_dest hold a write beat
//   bus_ready  sink accepts the current beat
//   bus_data   registered write data
//   bus_dest   registered destination: 00=Z/Rdest, 01=LO, 10=HI
//   busy       queue non-empty or a beat in progress
// -----------------------------------------------------------------------------
module alu_result_writeback #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  res_valid,
    output logic                  res_ready,
    input  logic [3:0]            ctl_in,
    input  logic [2*DATA_W-1:0]   C,
    output logic                  bus_valid,
    input  logic                  bus_ready,
    output logic [DATA_W-1:0]     bus_data,
    output logic [1:0]            bus_dest,
    output logic                  busy
);

    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 2 * DATA_W + 1;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SEND_LO = 2'd1;
    localparam logic [1:0] S_SEND_HI = 2'd2;

    // Opcodes that produce at least one beat.
    function automatic logic op_is_queued(input logic [3:0] op);
        logic r;
        case (op)
            4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8,
            4'd9, 4'd10, 4'd11, 4'd12: r = 1'b1;
            default:                   r = 1'b0;
        endcase
        return r;
    endfunction

    // mul and div write both LO and HI.
    function automatic logic op_is_double(input logic [3:0] op);
        logic r;
        case (op)
            4'd3, 4'd4: r = 1'b1;
            default:    r = 1'b0;
        endcase
        return r;
    endfunction

    logic [ENTRY_W-1:0]  mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [1:0]          state_q, state_d;
    logic [2*DATA_W-1:0] cur_c_q, cur_c_d;
    logic                cur_dbl_q, cur_dbl_d;
    logic                bus_valid_q, bus_valid_d;
    logic [DATA_W-1:0]   bus_data_q, bus_data_d;
    logic [1:0]          bus_dest_q, bus_dest_d;
    logic                busy_q, busy_d;

    logic                res_ready_s;
    logic                push_s;
    logic                pop_s;
    logic                beat_done_s;
    logic                load_next_s;
    logic [ENTRY_W-1:0]  head_s;

    // Next-state logic for the queue, the serializer and the registered bus outputs.
    always_comb begin
        // Full means refused, even if the head leaves this same cycle.
        res_ready_s = clear && (count_q < DEPTH_C);
        push_s      = res_valid && res_ready_s && op_is_queued(ctl_in);
        beat_done_s = bus_valid_q && bus_ready;
        head_s      = mem_q[rd_ptr_q];
        load_next_s = 1'b0;
        pop_s       = 1'b0;
        state_d     = state_q;
        cur_c_d     = cur_c_q;
        cur_dbl_d   = cur_dbl_q;
        bus_data_d  = bus_data_q;
        bus_dest_d  = bus_dest_q;

        case (state_q)
            S_IDLE: begin
                if (count_q != {CNT_W{1'b0}}) begin
                    load_next_s = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SEND_LO: begin
                if (beat_done_s) begin
                    if (cur_dbl_q) begin
                        state_d    = S_SEND_HI;
                        bus_data_d = cur_c_q[2*DATA_W-1:DATA_W];
                        bus_dest_d = 2'b10;
                    end else if (count_q != {CNT_W{1'b0}}) begin
                        load_next_s = 1'b1;
                    end else begin
                        state_d    = S_IDLE;
                        bus_data_d = {DATA_W{1'b0}};
                        bus_dest_d = 2'b00;
                    end
                end else begin
                    state_d = S_SEND_LO;
                end
            end
            S_SEND_HI: begin
                if (beat_done_s) begin
                    if (count_q != {CNT_W{1'b0}}) begin
                        load_next_s = 1'b1;
                    end else begin
                        state_d    = S_IDLE;
                        bus_data_d = {DATA_W{1'b0}};
                        bus_dest_d = 2'b00;
                    end
                end else begin
                    state_d = S_SEND_HI;
                end
            end
            default: begin
                state_d    = S_IDLE;
                bus_data_d = {DATA_W{1'b0}};
                bus_dest_d = 2'b00;
            end
        endcase

        // Pop the queue head straight into the LO beat; this keeps beats back-to-back.
        if (load_next_s) begin
            pop_s      = 1'b1;
            state_d    = S_SEND_LO;
            cur_c_d    = head_s[2*DATA_W-1:0];
            cur_dbl_d  = head_s[ENTRY_W-1];
            bus_data_d = head_s[DATA_W-1:0];
            bus_dest_d = head_s[ENTRY_W-1] ? 2'b01 : 2'b00;
        end else begin
            pop_s = 1'b0;
        end

        wr_ptr_d = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        bus_valid_d = (state_d != S_IDLE);
        busy_d      = (count_d != {CNT_W{1'b0}}) || (state_d != S_IDLE);
    end

    // Control and output registers with synchronous active-low clear.
    always_ff @(posedge clock) begin
        if (!clear) begin
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            count_q     <= {CNT_W{1'b0}};
            state_q     <= S_IDLE;
            cur_c_q     <= {(2*DATA_W){1'b0}};
            cur_dbl_q   <= 1'b0;
            bus_valid_q <= 1'b0;
            bus_data_q  <= {DATA_W{1'b0}};
            bus_dest_q  <= 2'b00;
            busy_q      <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            cur_c_q     <= cur_c_d;
            cur_dbl_q   <= cur_dbl_d;
            bus_valid_q <= bus_valid_d;
            bus_data_q  <= bus_data_d;
            bus_dest_q  <= bus_dest_d;
            busy_q      <= busy_d;
        end
    end

    // Queue storage. Stale entries are harmless because occupancy gates reads.
    always_ff @(posedge clock) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {op_is_double(ctl_in), C};
        end
    end

    assign res_ready = res_ready_s;
    assign bus_valid = bus_valid_q;
    assign bus_data  = bus_data_q;
    assign bus_dest  = bus_dest_q;
    assign busy      = busy_q;

endmodule
